lcd_bus_receiver: RTL and testbench
===================================

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40: cycles busy_o stays high after any accepted non-clear command or data write.
REQ-002 SHALL have parameter DISP_CHARS, default 32: display buffer depth, a power of two.
REQ-003 SHALL have ports: fpga_clk_i  in  1  sole clock, rising edge.
REQ-004 fpga_reset_i  in  1  reset; synchronous, active-high.
REQ-005 lcd_data_i  in  8  bus byte driven by the LCD controller.
REQ-006 lcd_reset_i  in  1  register select; 0 = command, 1 = character data.
REQ-007 lcd_enable_i  in  1  strobe; a transfer is taken on its falling edge.
REQ-008 rd_addr_i  in  5  display buffer read address; rd_data_o  out  8  buffer byte at rd_addr_i, combinational.
REQ-009 cursor_o  out  5  current cursor address; busy_o  out  1  receiver busy.
REQ-010 disp_on_o  out  1  display enable flag; cmd_valid_o  out  1  one-cycle pulse per accepted command; cmd_o  out  8  last accepted command byte.
REQ-011 overrun_o  out  1  sticky flag: a strobe arrived while busy.

Function
REQ-012 SHALL pass lcd_data_i, lcd_reset_i and lcd_enable_i through a common 2-flop synchronizer plus one history flop; a falling edge SHALL be synchronized-high followed by synchronized-low.
REQ-013 Edge effects (buffer write, cursor move, cmd_valid_o, busy_o rise) SHALL be visible after the 3rd rising clock edge that samples lcd_enable_i low.
REQ-014 FSM states: IDLE, CLEAR, BUSY; IDLE accepts strobes; CLEAR and BUSY reject them.
REQ-015 Data (RS=1) in IDLE: write byte to buffer[cursor]; cursor moves +1 or -1 per entry mode, wrapping modulo DISP_CHARS (31+1->0, 0-1->31); go BUSY.
REQ-016 Command 0x01 (clear): go CLEAR; write 0x20 to one entry per cycle, addresses 0..DISP_CHARS-1; cursor=0, entry mode=increment; then IDLE; busy_o high throughout.
REQ-017 Command 0x02/0x03 (home): cursor=0, buffer unchanged; go BUSY.
REQ-018 Command 0x04-0x07 (entry mode): bit1=1 increment, 0 decrement; go BUSY.
REQ-019 Command 0x08-0x0F (display control): disp_on_o=bit2; go BUSY.
REQ-020 Command 0x80-0xFF (set address): cursor=byte[4:0]; go BUSY.
REQ-021 Any other command byte SHALL be accepted (cmd_valid_o, cmd_o updated) with no other effect; go BUSY.
REQ-022 BUSY SHALL last exactly BUSY_CYCLES cycles, then IDLE.
REQ-023 A falling edge detected in CLEAR or BUSY SHALL be dropped: no state change, overrun_o set.
REQ-024 Falling edge on the cycle BUSY ends SHALL be dropped; IDLE must be registered first.
REQ-025 rd_data_o SHALL reflect a same-cycle buffer write one cycle later (no bypass).

Reset
REQ-026 On fpga_reset_i: state=IDLE, cursor_o=0, entry mode=increment, disp_on_o=0, busy_o=0, cmd_valid_o=0, cmd_o=0x00, overrun_o=0, synchronizer/history flops=0.
REQ-027 Buffer contents SHALL NOT be reset; reset mid-CLEAR SHALL abort the clear.

Configuration
REQ-028 Macro LCD_RX_OVERRUN_EN: defined -> REQ-023 overrun_o behaviour; undefined -> overrun_o tied 0 and no overrun logic; drop behaviour unchanged.

Structure
REQ-029 Shared package lcd_pkg SHALL hold the FSM state enum, command opcode/mask constants, and the 0x20 blank character.
REQ-030 Sub-module lcd_rx_sync SHALL implement the synchronizer and falling-edge detect.

Verification
REQ-031 Reset; write 'H','i' (RS=1) -> rd_data_o[0]=0x48, [1]=0x69, cursor_o=2.
REQ-032 Command 0x9F, then data 0x41 -> buffer[31]=0x41, cursor_o=0 (wrap).
REQ-033 Command 0x04, set 0x80, data 0x42 -> buffer[0]=0x42, cursor_o=31.
REQ-034 Command 0x01 -> busy_o high 32 cycles, all 32 entries 0x20, cursor_o=0.
REQ-035 Strobe 5 cycles after an accepted write (BUSY_CYCLES=40) -> dropped, buffer unchanged, overrun_o=1 (0 with LCD_RX_OVERRUN_EN undefined).
REQ-036 Reset asserted mid-CLEAR -> IDLE, busy_o=0, entries not yet cleared retain prior values.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus receiver.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSY  = 2'd2
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_bus_t;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_DISP_MASK  = 8'hF8;
  localparam logic [7:0] CMD_DISP       = 8'h08;
  localparam logic [7:0] CMD_ADDR_MASK  = 8'h80;
  localparam logic [7:0] CMD_ADDR       = 8'h80;
  localparam logic [7:0] BLANK_CHAR     = 8'h20;

  localparam int unsigned ENTRY_INC_BIT = 1;
  localparam int unsigned DISP_ON_BIT   = 2;

endpackage

// File: rtl/lcd_rx_sync.sv
// Two-flop synchronizer for the LCD bus plus strobe history for falling-edge detect.
module lcd_rx_sync
  import lcd_pkg::*;
(
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic [7:0] lcd_data_i,
  input  logic       lcd_reset_i,
  input  logic       lcd_enable_i,
  output lcd_bus_t   bus_o,
  output logic       fall_c
);

  localparam int unsigned SW = 10;

  logic [SW-1:0] meta_q;
  logic [SW-1:0] sync_q;
  logic          en_hist_q;

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      en_hist_q <= 1'b0;
    end else begin
      meta_q    <= {lcd_enable_i, lcd_reset_i, lcd_data_i};
      sync_q    <= meta_q;
      en_hist_q <= sync_q[SW-1];
    end
  end

  assign bus_o  = lcd_bus_t'(sync_q[SW-2:0]);
  assign fall_c = en_hist_q & ~sync_q[SW-1];

endmodule

// File: rtl/lcd_bus_receiver.sv
// LCD controller bus receiver: decodes commands/data into a display buffer and cursor.
// Optional sticky overrun flag enabled by defining LCD_RX_OVERRUN_EN.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 40,
  parameter int unsigned DISP_CHARS  = 32
) (
  input  logic                          fpga_clk_i,
  input  logic                          fpga_reset_i,
  input  logic [7:0]                    lcd_data_i,
  input  logic                          lcd_reset_i,
  input  logic                          lcd_enable_i,
  input  logic [$clog2(DISP_CHARS)-1:0] rd_addr_i,
  output logic [7:0]                    rd_data_o,
  output logic [$clog2(DISP_CHARS)-1:0] cursor_o,
  output logic                          busy_o,
  output logic                          disp_on_o,
  output logic                          cmd_valid_o,
  output logic [7:0]                    cmd_o,
  output logic                          overrun_o
);

  localparam int unsigned AW = $clog2(DISP_CHARS);
  localparam int unsigned CW = $clog2(BUSY_CYCLES + 1);

  lcd_bus_t   bus;
  logic       fall;
  lcd_state_e state_q, state_d;
  logic [AW-1:0] cursor_q, cursor_d, clr_q, clr_d, wr_addr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       inc_q, inc_d, disp_q, disp_d, cmd_valid_q, cmd_valid_d, busy_q, busy_d, wr_en;
  logic [7:0] cmd_q, cmd_d, wr_data;
  logic [7:0] mem_q [DISP_CHARS];

  lcd_rx_sync u_sync (
    .fpga_clk_i   (fpga_clk_i),
    .fpga_reset_i (fpga_reset_i),
    .lcd_data_i   (lcd_data_i),
    .lcd_reset_i  (lcd_reset_i),
    .lcd_enable_i (lcd_enable_i),
    .bus_o        (bus),
    .fall_c       (fall)
  );

  // State and control registers
  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      state_q     <= ST_IDLE;
      cursor_q    <= '0;
      clr_q       <= '0;
      cnt_q       <= '0;
      inc_q       <= 1'b1;
      disp_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      inc_q       <= inc_d;
      disp_q      <= disp_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state decode; strobes outside IDLE are ignored
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    clr_d       = clr_q;
    cnt_d       = cnt_q;
    inc_d       = inc_q;
    disp_d      = disp_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    wr_en       = 1'b0;
    wr_addr     = cursor_q;
    wr_data     = bus.data;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_BUSY;
          cnt_d   = CW'(BUSY_CYCLES - 1);
          if (bus.rs) begin
            wr_en    = 1'b1;
            cursor_d = inc_q ? cursor_q + AW'(1) : cursor_q - AW'(1);
          end else begin
            cmd_valid_d = 1'b1;
            cmd_d       = bus.data;
            if (bus.data == CMD_CLEAR) begin
              state_d  = ST_CLEAR;
              clr_d    = '0;
              cursor_d = '0;
              inc_d    = 1'b1;
            end else if ((bus.data & CMD_HOME_MASK) == CMD_HOME) begin
              cursor_d = '0;
            end else if ((bus.data & CMD_ENTRY_MASK) == CMD_ENTRY) begin
              inc_d = bus.data[ENTRY_INC_BIT];
            end else if ((bus.data & CMD_DISP_MASK) == CMD_DISP) begin
              disp_d = bus.data[DISP_ON_BIT];
            end else if ((bus.data & CMD_ADDR_MASK) == CMD_ADDR) begin
              cursor_d = bus.data[AW-1:0];
            end
          end
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_q;
        wr_data = BLANK_CHAR;
        clr_d   = clr_q + AW'(1);
        if (clr_q == AW'(DISP_CHARS - 1)) state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Display buffer is not reset; a reset edge must not complete a pending clear write
  always_ff @(posedge fpga_clk_i) begin
    if (wr_en && !fpga_reset_i) mem_q[wr_addr] <= wr_data;
  end

`ifdef LCD_RX_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i)                      overrun_q <= 1'b0;
    else if (fall && (state_q != ST_IDLE)) overrun_q <= 1'b1;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

  assign rd_data_o   = mem_q[rd_addr_i];
  assign cursor_o    = cursor_q;
  assign busy_o      = busy_q;
  assign disp_on_o   = disp_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboarded bench for lcd_bus_receiver: command queue plus per-scenario buffer checks.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       fpga_reset = 1'b1;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_enable = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       busy, disp_on, cmd_valid, overrun;
  logic [7:0] cmd;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cmd[$];
  logic [7:0] obs_cmd[$];

`ifdef LCD_RX_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  lcd_bus_receiver #(.BUSY_CYCLES(40), .DISP_CHARS(32)) dut (
    .fpga_clk_i   (clk),
    .fpga_reset_i (fpga_reset),
    .lcd_data_i   (lcd_data),
    .lcd_reset_i  (lcd_rs),
    .lcd_enable_i (lcd_enable),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .cursor_o     (cursor),
    .busy_o       (busy),
    .disp_on_o    (disp_on),
    .cmd_valid_o  (cmd_valid),
    .cmd_o        (cmd),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_valid === 1'b1) obs_cmd.push_back(cmd);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests not complete");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic rs, input logic [7:0] d, input bit accept);
    @(negedge clk);
    lcd_rs = rs; lcd_data = d; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    lcd_enable = 1'b0;
    if (accept && !rs) exp_cmd.push_back(d);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500 && busy !== 1'b0; n++) @(negedge clk);
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy=%b, required 0 within 500 cycles", busy);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    strobe(rs, d, 1'b1);
    repeat (4) @(negedge clk);
    wait_idle();
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = 5'(a);
    #1 v = rd_data;
  endtask

  task automatic test_reset();
    fpga_reset = 1'b1;
    repeat (3) @(negedge clk);
    fpga_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL reset_cursor: got %0d, required 0", cursor); end
    checks++;
    if ({busy, disp_on, cmd_valid, cmd, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_flags: busy=%b disp=%b vld=%b cmd=%h ovr=%b, required all 0",
               busy, disp_on, cmd_valid, cmd, overrun);
    end
  endtask

  task automatic test_hi();
    logic [7:0] v0, v1;
    send(1'b1, 8'h48);
    send(1'b1, 8'h69);
    rd(0, v0); rd(1, v1);
    checks++;
    if (v0 !== 8'h48) begin errors++; $display("FAIL hi_buf0: got %h, required 48", v0); end
    checks++;
    if (v1 !== 8'h69) begin errors++; $display("FAIL hi_buf1: got %h, required 69", v1); end
    checks++;
    if (cursor !== 5'd2) begin errors++; $display("FAIL hi_cursor: got %0d, required 2", cursor); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    send(1'b0, 8'h9F);
    send(1'b1, 8'h41);
    rd(31, v);
    checks++;
    if (v !== 8'h41) begin errors++; $display("FAIL wrap_buf31: got %h, required 41", v); end
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL wrap_cursor: got %0d, required 0", cursor); end
  endtask

  task automatic test_decrement();
    logic [7:0] v;
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    send(1'b1, 8'h42);
    rd(0, v);
    checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL dec_buf0: got %h, required 42", v); end
    checks++;
    if (cursor !== 5'd31) begin errors++; $display("FAIL dec_cursor: got %0d, required 31", cursor); end
  endtask

  task automatic test_commands();
    logic [7:0] v, e, o;
    send(1'b0, 8'h0C);
    checks++;
    if (disp_on !== 1'b1) begin errors++; $display("FAIL disp_on: got %b, required 1", disp_on); end
    send(1'b0, 8'h08);
    checks++;
    if (disp_on !== 1'b0) begin errors++; $display("FAIL disp_off: got %b, required 0", disp_on); end
    send(1'b0, 8'h8A);
    checks++;
    if (cursor !== 5'd10) begin errors++; $display("FAIL set_addr: got %0d, required 10", cursor); end
    send(1'b0, 8'h03);
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL home: got %0d, required 0", cursor); end
    send(1'b0, 8'h10);
    checks++;
    if ({cmd, cursor, disp_on} !== {8'h10, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL other_cmd: cmd=%h cursor=%0d disp=%b, required 10/0/0", cmd, cursor, disp_on);
    end
    rd(31, v);
    checks++;
    if (v !== 8'h41) begin errors++; $display("FAIL cmd_buf_kept: got %h, required 41", v); end
    while (exp_cmd.size() != 0) begin
      e = exp_cmd.pop_front();
      checks++;
      if (obs_cmd.size() == 0) begin
        errors++; $display("FAIL cmd_scoreboard: got none, required %h", e);
      end else begin
        o = obs_cmd.pop_front();
        if (o !== e) begin errors++; $display("FAIL cmd_scoreboard: got %h, required %h", o, e); end
      end
    end
    checks++;
    if (obs_cmd.size() != 0) begin
      errors++; $display("FAIL cmd_extra: got %0d extra pulses, required 0", obs_cmd.size());
    end
  endtask

  task automatic test_clear();
    int hi = 0;
    int bad = 0;
    bit seen = 0;
    logic [7:0] v, o;
    strobe(1'b0, 8'h01, 1'b1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy === 1'b1) begin hi++; seen = 1; end
      else if (seen) break;
    end
    checks++;
    if (hi != 32) begin errors++; $display("FAIL clear_busy_len: got %0d, required 32", hi); end
    for (int i = 0; i < 32; i++) begin
      rd(i, v);
      if (v !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_entries: got %0d non-blank, required 0", bad); end
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL clear_cursor: got %0d, required 0", cursor); end
    checks++;
    o = (obs_cmd.size() != 0) ? obs_cmd.pop_front() : 8'hxx;
    if (o !== exp_cmd.pop_front()) begin errors++; $display("FAIL clear_cmd: got %h, required 01", o); end
    send(1'b1, 8'h5A);
    rd(0, v);
    checks++;
    if ({v, cursor} !== {8'h5A, 5'd1}) begin
      errors++; $display("FAIL clear_inc_mode: buf0=%h cursor=%0d, required 5a/1", v, cursor);
    end
  endtask

  task automatic test_busy_len();
    int hi = 0;
    bit seen = 0;
    strobe(1'b1, 8'h33, 1'b1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy === 1'b1) begin hi++; seen = 1; end
      else if (seen) break;
    end
    checks++;
    if (hi != 40) begin errors++; $display("FAIL busy_len: got %0d, required 40", hi); end
    checks++;
    if (cursor !== 5'd2) begin errors++; $display("FAIL busy_cursor: got %0d, required 2", cursor); end
  endtask

  task automatic test_overrun();
    logic [7:0] v2, v3;
    strobe(1'b1, 8'h44, 1'b1);
    repeat (2) @(negedge clk);
    strobe(1'b1, 8'h99, 1'b0);
    repeat (4) @(negedge clk);
    wait_idle();
    rd(2, v2); rd(3, v3);
    checks++;
    if ({v2, v3} !== {8'h44, 8'h20}) begin
      errors++; $display("FAIL overrun_buf: buf2=%h buf3=%h, required 44/20", v2, v3);
    end
    checks++;
    if (cursor !== 5'd3) begin errors++; $display("FAIL overrun_cursor: got %0d, required 3", cursor); end
    checks++;
    if (overrun !== EXP_OVR) begin errors++; $display("FAIL overrun_flag: got %b, required %b", overrun, EXP_OVR); end
    checks++;
    if (obs_cmd.size() != 0) begin
      errors++; $display("FAIL overrun_cmd: got %0d pulses, required 0", obs_cmd.size());
    end
  endtask

  task automatic test_end_of_busy();
    logic [7:0] v;
    int n;
    strobe(1'b1, 8'h55, 1'b1);
    for (n = 0; n < 20 && busy !== 1'b1; n++) @(negedge clk);
    if (busy !== 1'b1) begin
      checks++; errors++; $display("FAIL eob_rise: busy=%b, required 1", busy);
    end
    repeat (30) @(negedge clk);
    lcd_rs = 1'b1; lcd_data = 8'h77; lcd_enable = 1'b1;
    repeat (7) @(negedge clk);
    lcd_enable = 1'b0;
    repeat (6) @(negedge clk);
    wait_idle();
    rd(4, v);
    checks++;
    if ({v, cursor} !== {8'h20, 5'd4}) begin
      errors++; $display("FAIL eob_drop: buf4=%h cursor=%0d, required 20/4", v, cursor);
    end
    send(1'b1, 8'h66);
    rd(4, v);
    checks++;
    if ({v, cursor} !== {8'h66, 5'd5}) begin
      errors++; $display("FAIL eob_next: buf4=%h cursor=%0d, required 66/5", v, cursor);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] v;
    int bad = 0;
    int n;
    send(1'b0, 8'h94);
    for (int i = 20; i < 32; i++) send(1'b1, 8'(8'h60 + i));
    strobe(1'b0, 8'h01, 1'b1);
    for (n = 0; n < 20 && busy !== 1'b1; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    fpga_reset = 1'b1;
    repeat (2) @(negedge clk);
    fpga_reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, cursor, cmd} !== {1'b0, 5'd0, 8'h00}) begin
      errors++; $display("FAIL rst_clear_state: busy=%b cursor=%0d cmd=%h, required 0/0/00", busy, cursor, cmd);
    end
    for (int i = 20; i < 32; i++) begin
      rd(i, v);
      if (v !== 8'(8'h60 + i)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_clear_kept: got %0d altered, required 0", bad); end
    rd(0, v);
    checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL rst_clear_started: buf0=%h, required 20", v); end
    exp_cmd.delete();
    obs_cmd.delete();
  endtask

  initial begin
    test_reset();
    test_hi();
    test_wrap();
    test_decrement();
    test_commands();
    test_clear();
    test_busy_len();
    test_overrun();
    test_end_of_busy();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
